// File: rtl/uart_pkg.sv
// Shared UART types and baud constants.
// 115200 baud from a 100 MHz clock.
package uart_pkg;

  localparam int UART_DATA_W      = 8;
  localparam int UART_PERIOD      = 868;
  localparam int UART_HALF_PERIOD = 434;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// Byte array for the TX FIFO.
// Synchronous write port, asynchronous read port.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [UART_DATA_W-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [UART_DATA_W-1:0] rdata
);

  uart_byte_t mem [1<<AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter, one pop per ack rising edge.
// Sticky overflow flag built only with UART_TX_FIFO_OVF_EN defined.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   wr_en,
  output logic                   full,
  output logic                   empty,
  output logic [DEPTH_LOG2:0]    level,
  output logic                   overflow,
  input  logic                   ovf_clr,
  output logic [UART_DATA_W-1:0] tx_din,
  output logic                   tx_ready,
  input  logic                   tx_ack
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_MAX =
    (DEPTH_LOG2+1)'(DEPTH);

  logic [DEPTH_LOG2-1:0] wp;
  logic [DEPTH_LOG2-1:0] rp;
  logic [DEPTH_LOG2:0]   lvl_q;
  logic                  ack_q;
  logic                  pop;
  logic                  push;
  logic                  drop;

  assign full     = (lvl_q == LVL_MAX);
  assign empty    = (lvl_q == '0);
  assign level    = lvl_q;
  assign tx_ready = !empty;

  // The transmitter has already latched din when ack rises.
  assign pop  = tx_ack && !ack_q && !empty;
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && full && !pop;

  uart_fifo_ram #(
    .AW(DEPTH_LOG2)
  ) u_ram (
    .clk  (clk),
    .we   (push),
    .waddr(wp),
    .wdata(wr_data),
    .raddr(rp),
    .rdata(tx_din)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      lvl_q <= '0;
      ack_q <= 1'b0;
    end else begin
      ack_q <= tx_ack;
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      if (push && !pop) begin
        lvl_q <= lvl_q + 1'b1;
      end else if (pop && !push) begin
        lvl_q <= lvl_q - 1'b1;
      end
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow = ovf_q;
`else
  logic ovf_unused;

  assign ovf_unused = ovf_clr ^ drop;
  assign overflow   = 1'b0;
`endif

endmodule
